// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART RX controller and its sampler.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned EDGE_W_DEF     = 6;
    localparam int unsigned BIT_W_DEF      = 4;

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point mid-bit capture of RX_IN with a 2-of-3 majority vote.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned EDGE_W = EDGE_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic [EDGE_W-1:0] edge_cnt,
    input  logic [EDGE_W-1:0] prescale,
    output logic              sampled_bit
);

    logic [EDGE_W-1:0] mid;
    logic [2:0]        smp;

    assign mid = prescale >> 1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            smp <= '0;
        end else begin
            if (edge_cnt == mid - EDGE_W'(1)) smp[0] <= RX_IN;
            if (edge_cnt == mid)              smp[1] <= RX_IN;
            if (edge_cnt == mid + EDGE_W'(1)) smp[2] <= RX_IN;
        end
    end

    assign sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, deserialisation, parity/stop checks.
// Drives the external bit/edge counter and consumes its counts.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned EDGE_W     = EDGE_W_DEF,
    parameter int unsigned BIT_W      = BIT_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [EDGE_W-1:0]     Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [BIT_W-1:0]      bit_cnt,
    input  logic [EDGE_W-1:0]     edge_cnt,
    output logic                  cnt_enable,
    output logic [EDGE_W-1:0]     cnt_prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    state_e                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_fail;
    logic                  sampled_bit;
    logic                  decision;
    logic                  last_data_bit;
    logic                  exp_parity;

    uart_rx_sampler #(
        .EDGE_W (EDGE_W)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .edge_cnt    (edge_cnt),
        .prescale    (cnt_prescale),
        .sampled_bit (sampled_bit)
    );

    assign decision      = (edge_cnt == cnt_prescale - EDGE_W'(1));
    assign last_data_bit = (bit_cnt == BIT_W'(DATA_WIDTH));
    assign exp_parity    = (^shreg) ^ par_typ_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            cnt_enable   <= 1'b0;
            cnt_prescale <= EDGE_W'(PRESCALE_8);
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
            shreg        <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_fail     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        state        <= START;
                        cnt_enable   <= 1'b1;
                        cnt_prescale <= Prescale;
                        par_en_q     <= PAR_EN;
                        par_typ_q    <= PAR_TYP;
                        par_fail     <= 1'b0;
                    end
                end
                START: begin
                    if (decision) begin
                        if (sampled_bit) begin
                            state      <= IDLE;
                            cnt_enable <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    // line order is LSB first, so each bit enters at the MSB
                    if (decision) begin
                        shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
                        if (last_data_bit) state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (decision) begin
                        par_fail <= (sampled_bit != exp_parity);
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (decision) begin
                        state      <= IDLE;
                        cnt_enable <= 1'b0;
                        stp_err    <= ~sampled_bit;
                        par_err    <= par_fail;
                        if (sampled_bit && !par_fail) begin
                            data_valid <= 1'b1;
                            P_DATA     <= shreg;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl with a behavioural RX counter, a line-level frame
// encoder and a pulse monitor checked against an expected-outcome model.
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam int EW = 6;
    localparam int BW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic [EW-1:0] Prescale = EW'(8);
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [BW-1:0] bit_cnt;
    logic [EW-1:0] edge_cnt;
    logic          cnt_enable;
    logic [EW-1:0] cnt_prescale;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    uart_rx_ctrl #(
        .DATA_WIDTH (DW),
        .EDGE_W     (EW),
        .BIT_W      (BW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .bit_cnt      (bit_cnt),
        .edge_cnt     (edge_cnt),
        .cnt_enable   (cnt_enable),
        .cnt_prescale (cnt_prescale),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err)
    );

    always #5 CLK = ~CLK;

    // Stand-in for the RX bit/edge counter.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!cnt_enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == cnt_prescale - EW'(1)) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BW'(1);
        end else begin
            edge_cnt <= edge_cnt + EW'(1);
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic          dv;
        logic          pe;
        logic          se;
        logic [DW-1:0] d;
    } ev_t;
    ev_t evq[$];

    always @(posedge CLK) begin
        #1;
        if (data_valid !== 1'b0 || par_err !== 1'b0 || stp_err !== 1'b0)
            evq.push_back('{cyc, data_valid, par_err, stp_err, P_DATA});
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_pdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit line_parity(input logic [DW-1:0] d, input bit odd);
        return (^d) ^ odd;
    endfunction

    // Drives one frame starting at a negedge; returns at the negedge after the
    // stop bit's last cycle. det is the cycle count once the start is detected.
    task automatic send_frame(input logic [DW-1:0] data, input int p, input bit pe,
                              input bit pt, input bit pbit, input bit sbit,
                              input bit scramble, output int det);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(data[i]);
        if (pe) bits.push_back(pbit);
        bits.push_back(sbit);
        Prescale = EW'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        det      = cyc + 1;
        for (int b = 0; b < bits.size(); b++) begin
            RX_IN = bits[b];
            if (scramble && b == 3) begin
                Prescale = EW'(8);
                PAR_EN   = ~pe;
                PAR_TYP  = ~pt;
            end
            if (scramble && b == 5) chk("cfg_latched_prescale", 32'(cnt_prescale), 32'(p));
            repeat (p) @(negedge CLK);
        end
    endtask

    task automatic check_frame(input string nm, input int det, input int lat,
                               input bit dv, input bit pe, input bit se,
                               input logic [DW-1:0] data);
        ev_t ev;
        if (evq.size() == 0) begin
            chk({nm, "_pulse_seen"}, 32'd0, 32'd1);
            return;
        end
        ev = evq.pop_front();
        if (dv) exp_pdata = data;
        chk({nm, "_latency"}, 32'(ev.cyc - det), 32'(lat));
        chk({nm, "_data_valid"}, 32'(ev.dv), 32'(dv));
        chk({nm, "_par_err"}, 32'(ev.pe), 32'(pe));
        chk({nm, "_stp_err"}, 32'(ev.se), 32'(se));
        chk({nm, "_P_DATA"}, 32'(ev.d), 32'(exp_pdata));
    endtask

    task automatic run_frame(input string nm, input logic [DW-1:0] data, input int p,
                             input bit pe, input bit pt, input bit pbit, input bit sbit,
                             input bit dv, input bit perr, input bit serr, input int gap);
        int det;
        send_frame(data, p, pe, pt, pbit, sbit, 1'b0, det);
        RX_IN = 1'b1;
        repeat (3 + gap) @(negedge CLK);
        check_frame(nm, det, p * (DW + 2 + int'(pe)), dv, perr, serr, data);
        chk({nm, "_no_extra_pulse"}, 32'(evq.size()), 32'd0);
        chk({nm, "_cnt_enable_idle"}, 32'(cnt_enable), 32'd0);
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            p;
        bit            pe, pt, pbit, sbit;
        bit            dv, perr, serr;
    } vec_t;
    vec_t vt[6];

    task automatic check_reset_values(input string nm);
        chk({nm, "_cnt_enable"}, 32'(cnt_enable), 32'd0);
        chk({nm, "_cnt_prescale"}, 32'(cnt_prescale), 32'd8);
        chk({nm, "_P_DATA"}, 32'(P_DATA), 32'd0);
        chk({nm, "_flags"}, {29'd0, data_valid, par_err, stp_err}, 32'd0);
    endtask

    initial begin
        int det1, det2, r, p;
        bit pe, pt, flip, sbad;
        logic [DW-1:0] d;
        ev_t e1, e2;

        vt[0] = '{8'hA5, 8,  1, 0, 0, 1, 1, 0, 0};
        vt[1] = '{8'hA5, 8,  1, 0, 1, 1, 0, 1, 0};
        vt[2] = '{8'h3C, 16, 0, 0, 0, 0, 0, 0, 1};
        vt[3] = '{8'hFF, 32, 1, 1, 1, 1, 1, 0, 0};
        vt[4] = '{8'h01, 16, 1, 1, 0, 1, 1, 0, 0};
        vt[5] = '{8'h00, 8,  1, 0, 1, 0, 0, 1, 1};

        #23;
        check_reset_values("reset");
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);

        for (int i = 0; i < 6; i++)
            run_frame($sformatf("vec%0d", i), vt[i].data, vt[i].p, vt[i].pe, vt[i].pt,
                      vt[i].pbit, vt[i].sbit, vt[i].dv, vt[i].perr, vt[i].serr, 0);

        // Glitch: two low cycles, rejected at the START decision (edge 7).
        Prescale = EW'(8);
        RX_IN = 1'b0;
        @(negedge CLK);
        chk("glitch_cnt_enable_on", 32'(cnt_enable), 32'd1);
        @(negedge CLK);
        RX_IN = 1'b1;
        repeat (6) @(negedge CLK);
        chk("glitch_still_start", 32'(cnt_enable), 32'd1);
        @(negedge CLK);
        chk("glitch_rejected", 32'(cnt_enable), 32'd0);
        repeat (4) @(negedge CLK);
        chk("glitch_no_pulse", 32'(evq.size()), 32'd0);

        // Back-to-back at P=16, config scrambled mid frame 1. Frame 2's start
        // arrives during frame 1's STOP decision, so it is detected one cycle later.
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, det1);
        send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, det2);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        chk("b2b_pulse_count", 32'(evq.size()), 32'd2);
        if (evq.size() == 2) begin
            e1 = evq[0];
            e2 = evq[1];
            evq.delete();
            chk("b2b_f1_latency", 32'(e1.cyc - det1), 32'd160);
            chk("b2b_f1_data", {29'd0, e1.dv, e1.pe, e1.se}, 32'd4);
            chk("b2b_f1_P_DATA", 32'(e1.d), 32'h3C);
            chk("b2b_f2_data", {29'd0, e2.dv, e2.pe, e2.se}, 32'd4);
            chk("b2b_f2_P_DATA", 32'(e2.d), 32'hC3);
            chk("b2b_spacing", 32'(e2.cyc - e1.cyc), 32'd161);
            exp_pdata = 8'hC3;
        end
        evq.delete();

        // Reset in the middle of DATA of 0x5A.
        Prescale = EW'(16);
        PAR_EN   = 1'b1;
        d = 8'h5A;
        RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            RX_IN = d[i];
            repeat (8) @(negedge CLK);
        end
        chk("abort_mid_frame_active", 32'(cnt_enable), 32'd1);
        RST = 1'b0;
        #1;
        check_reset_values("abort_in_reset");
        exp_pdata = '0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        check_reset_values("abort_held");
        RST = 1'b1;
        repeat (120) @(negedge CLK);
        chk("abort_no_pulse", 32'(evq.size()), 32'd0);
        run_frame("after_reset", 8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        // Randomised frames against the outcome model.
        for (int n = 0; n < 24; n++) begin
            r    = int'($urandom_range(0, 2));
            p    = 8 << r;
            d    = DW'($urandom);
            pe   = bit'($urandom_range(0, 1));
            pt   = bit'($urandom_range(0, 1));
            flip = ($urandom_range(0, 4) == 0);
            sbad = ($urandom_range(0, 4) == 0);
            run_frame($sformatf("rand%0d", n), d, p, pe, pt, line_parity(d, pt) ^ flip, ~sbad,
                      !(pe && flip) && !sbad, pe && flip, sbad, int'($urandom_range(0, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
